// File: rtl/ip_crpr_pkg.sv
// ip_crpr_pkg: shared widths and FSM state type for the credit tracker.
// Used by ip_crpr_cnt and ip_crpr_track.
package ip_crpr_pkg;

   // Header credit counters are 8 bits wide; data credit counters are 12 bits wide.
   localparam int unsigned HDR_W = 8;
   localparam int unsigned DAT_W = 12;

   // Request-handling FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EVAL  = 2'd1,
      ST_GRANT = 2'd2,
      ST_DROP  = 2'd3
   } crpr_state_t;

endpackage : ip_crpr_pkg

// File: rtl/ip_crpr_cnt.sv
// ip_crpr_cnt: one saturating credit counter.
// Holds the limit captured on load.  Each cycle it adds the released credits,
// clamps the sum at that limit and then subtracts the consumed credits.
// The caller must never request a subtract larger than the current count.
// clamp pulses for one cycle when the sum would have exceeded the limit.
module ip_crpr_cnt
   import ip_crpr_pkg::*;
#(
   parameter int unsigned W = HDR_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] lim,
   input  logic [W-1:0] add,
   input  logic [W-1:0] sub,
   output logic [W-1:0] cnt,
   output logic         clamp
);

   logic [W-1:0] lim_q;
   logic [W:0]   sum;
   logic [W-1:0] sat;
   logic         over;

   // Release path: widen by one bit so the sum cannot wrap, then clamp at the limit.
   always_comb begin
      sum  = {1'b0, cnt} + {1'b0, add};
      sat  = sum[W-1:0];
      over = 1'b0;
      if (sum > {1'b0, lim_q}) begin
         sat  = lim_q;
         over = 1'b1;
      end
   end

   // A load cycle discards releases, so it never reports a clamp.
   always_comb begin
      clamp = over & ~load;
   end

   // Counter and captured limit; load takes priority over release and consume.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= '0;
         lim_q <= '0;
      end else if (load) begin
         cnt   <= lim;
         lim_q <= lim;
      end else begin
         cnt <= sat - sub;
      end
   end

endmodule : ip_crpr_cnt

// File: rtl/ip_crpr_track.sv
// ip_crpr_track: transmit credit tracker for posted / non-posted traffic.
// Four ip_crpr_cnt instances hold the ph/pd/nph/npd available credits.
// A small FSM evaluates each held tx_req against the registered counts.
// It grants with a one-cycle registered tx_gnt pulse and consumes the
// credits on that grant cycle.
// Optional over-release checking: define IP_CRPR_OVF_CHK_EN to make ovf_err
// a sticky flag set by any counter clamp.  Otherwise ovf_err is tied to 0.
module ip_crpr_track
   import ip_crpr_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        init,
   input  logic [7:0]  ph_lim,
   input  logic [11:0] pd_lim,
   input  logic [7:0]  nph_lim,
   input  logic [11:0] npd_lim,
   input  logic        ph_cr,
   input  logic        pd_cr,
   input  logic [7:0]  pd_num,
   input  logic        nph_cr,
   input  logic        npd_cr,
   input  logic        tx_req,
   input  logic        tx_np,
   input  logic [7:0]  tx_dcr,
   output logic        tx_gnt,
   output logic [7:0]  ph_av,
   output logic [11:0] pd_av,
   output logic [7:0]  nph_av,
   output logic [11:0] npd_av,
   output logic        ovf_err
);

   crpr_state_t state;
   logic        req_np;
   logic [7:0]  req_dcr;

   logic        posted_ok;
   logic        np_ok;
   logic        suff;

   logic [HDR_W-1:0] ph_add, nph_add, ph_sub, nph_sub;
   logic [DAT_W-1:0] pd_add, npd_add, pd_sub, npd_sub;
   logic [3:0]       clamp_vec;

   // Sufficiency test against the registered counters for the pending request.
   always_comb begin
      posted_ok = (ph_av != '0) && ({4'b0, tx_dcr} <= pd_av);
      np_ok     = (nph_av != '0) && ({4'b0, tx_dcr} <= npd_av);
      suff      = tx_np ? np_ok : posted_ok;
   end

   // Release amounts: one credit per pulse, pd_num data credits on pd_cr.
   always_comb begin
      ph_add  = {7'b0, ph_cr};
      nph_add = {7'b0, nph_cr};
      npd_add = {11'b0, npd_cr};
      pd_add  = pd_cr ? {4'b0, pd_num} : '0;
   end

   // Consume amounts use the request captured when EVAL passed.
   // They apply only during the grant cycle.
   always_comb begin
      ph_sub  = '0;
      pd_sub  = '0;
      nph_sub = '0;
      npd_sub = '0;
      if (state == ST_GRANT) begin
         if (req_np) begin
            nph_sub = {7'b0, 1'b1};
            npd_sub = {4'b0, req_dcr};
         end else begin
            ph_sub  = {7'b0, 1'b1};
            pd_sub  = {4'b0, req_dcr};
         end
      end
   end

   ip_crpr_cnt #(.W(HDR_W)) u_ph (
      .clk   (clk),
      .rstn  (rstn),
      .load  (init),
      .lim   (ph_lim),
      .add   (ph_add),
      .sub   (ph_sub),
      .cnt   (ph_av),
      .clamp (clamp_vec[0])
   );

   ip_crpr_cnt #(.W(DAT_W)) u_pd (
      .clk   (clk),
      .rstn  (rstn),
      .load  (init),
      .lim   (pd_lim),
      .add   (pd_add),
      .sub   (pd_sub),
      .cnt   (pd_av),
      .clamp (clamp_vec[1])
   );

   ip_crpr_cnt #(.W(HDR_W)) u_nph (
      .clk   (clk),
      .rstn  (rstn),
      .load  (init),
      .lim   (nph_lim),
      .add   (nph_add),
      .sub   (nph_sub),
      .cnt   (nph_av),
      .clamp (clamp_vec[2])
   );

   ip_crpr_cnt #(.W(DAT_W)) u_npd (
      .clk   (clk),
      .rstn  (rstn),
      .load  (init),
      .lim   (npd_lim),
      .add   (npd_add),
      .sub   (npd_sub),
      .cnt   (npd_av),
      .clamp (clamp_vec[3])
   );

   // Request FSM with registered grant pulse.
   // tx_gnt is set on the same edge that enters GRANT, so it is high for exactly
   // the GRANT cycle.  tx_np/tx_dcr are captured on that edge so that the
   // consume does not depend on the requester holding them through GRANT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         tx_gnt  <= 1'b0;
         req_np  <= 1'b0;
         req_dcr <= '0;
      end else if (init) begin
         state  <= ST_IDLE;
         tx_gnt <= 1'b0;
      end else begin
         tx_gnt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_req) state <= ST_EVAL;
            end
            ST_EVAL: begin
               if (!tx_req) begin
                  state <= ST_IDLE;
               end else if (suff) begin
                  state   <= ST_GRANT;
                  tx_gnt  <= 1'b1;
                  req_np  <= tx_np;
                  req_dcr <= tx_dcr;
               end
            end
            ST_GRANT: begin
               state <= ST_DROP;
            end
            ST_DROP: begin
               if (!tx_req) state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef IP_CRPR_OVF_CHK_EN
   logic ovf_q;

   // Sticky over-release flag, cleared by reset or init.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
      end else if (init) begin
         ovf_q <= 1'b0;
      end else if (|clamp_vec) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf_err = ovf_q;
`else
   logic unused_clamp;
   assign unused_clamp = |clamp_vec;
   assign ovf_err      = 1'b0;
`endif

endmodule : ip_crpr_track
